// File: rtl/seven_segment_scanner_pkg.sv
// rtl/seven_segment_scanner_pkg.sv - shared segment patterns and converter state type
package seven_segment_scanner_pkg;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_COMMIT
  } conv_state_t;

  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic       ANODE_OFF = 1'b1;

  // Active-low {a,b,c,d,e,f,g}; non-decimal nibbles show nothing.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_segment_scanner_bin_to_bcd_seq.sv
// rtl/seven_segment_scanner_bin_to_bcd_seq.sv - sequential double-dabble converter with one-deep pending load
module bin_to_bcd_seq
  import seven_segment_scanner_pkg::*;
#(
  parameter int BIN_WIDTH  = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BIN_WIDTH-1:0]    value,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    overflow
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam longint MAX_VAL = longint'(10) ** NUM_DIGITS - 1;
  localparam logic [BIN_WIDTH-1:0] MAX_BIN = BIN_WIDTH'(MAX_VAL);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_WIDTH - 1);

  generate
    if ((longint'(1) << BIN_WIDTH) - 1 < MAX_VAL) begin : g_width_check
      $error("BIN_WIDTH cannot hold the largest NUM_DIGITS decimal value");
    end
  endgenerate

  conv_state_t            state, state_d;
  logic [BIN_WIDTH-1:0]   bin_sr;
  logic [BCD_W-1:0]       bcd_sr, bcd_adj;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   ovf_cap;
  logic                   pend;
  logic [BIN_WIDTH-1:0]   pend_val;
  logic                   capture;
  logic [BIN_WIDTH-1:0]   cap_val;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= CONV_IDLE;
    else       state <= state_d;
  end

  // In COMMIT a fresh load beats the pending one, so the last value wins.
  always_comb begin
    state_d = state;
    capture = 1'b0;
    cap_val = value;
    case (state)
      CONV_IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_d = CONV_SHIFT;
        end
      end
      CONV_SHIFT: begin
        if (bit_cnt == LAST_BIT) state_d = CONV_COMMIT;
      end
      CONV_COMMIT: begin
        if (start || pend) begin
          capture = 1'b1;
          cap_val = start ? value : pend_val;
          state_d = CONV_SHIFT;
        end else begin
          state_d = CONV_IDLE;
        end
      end
      default: state_d = CONV_IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bin_sr   <= '0;
      bcd_sr   <= '0;
      bit_cnt  <= '0;
      ovf_cap  <= 1'b0;
      pend     <= 1'b0;
      pend_val <= '0;
    end else begin
      if (capture) begin
        bin_sr  <= cap_val;
        bcd_sr  <= '0;
        bit_cnt <= '0;
        ovf_cap <= (cap_val > MAX_BIN);
      end else if (state == CONV_SHIFT) begin
        bcd_sr  <= {bcd_adj[BCD_W-2:0], bin_sr[BIN_WIDTH-1]};
        bin_sr  <= {bin_sr[BIN_WIDTH-2:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (capture) begin
        pend <= 1'b0;
      end else if (start && state != CONV_IDLE) begin
        pend     <= 1'b1;
        pend_val <= value;
      end
    end
  end

  assign busy     = (state != CONV_IDLE);
  assign done     = (state == CONV_COMMIT);
  assign bcd      = bcd_sr;
  assign overflow = ovf_cap;

endmodule

// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - multiplexed 7-segment driver with BCD conversion, blanking and PWM brightness
module seven_segment_scanner
  import seven_segment_scanner_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int BIN_WIDTH   = 14,
  parameter int SLOT_BITS   = 15,
  parameter int BRIGHT_BITS = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [BIN_WIDTH-1:0]   value,
  input  logic                   load,
  input  logic [NUM_DIGITS-1:0]  dp_mask,
  input  logic                   blank_leading,
  input  logic [BRIGHT_BITS-1:0] brightness,
  output logic [NUM_DIGITS-1:0]  anode_signals,
  output logic [6:0]             display_out,
  output logic                   dp_out,
  output logic                   busy,
  output logic                   overflow
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic                    conv_done;
  logic [4*NUM_DIGITS-1:0] conv_bcd;
  logic                    conv_ovf;
  logic [4*NUM_DIGITS-1:0] digits;

  bin_to_bcd_seq #(
    .BIN_WIDTH (BIN_WIDTH),
    .NUM_DIGITS(NUM_DIGITS)
  ) u_conv (
    .clock   (clock),
    .reset   (reset),
    .start   (load),
    .value   (value),
    .busy    (busy),
    .done    (conv_done),
    .bcd     (conv_bcd),
    .overflow(conv_ovf)
  );

  // Digits and overflow change together so the display never shows a half-updated value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digits   <= '0;
      overflow <= 1'b0;
    end else if (conv_done) begin
      digits   <= conv_bcd;
      overflow <= conv_ovf;
    end
  end

  logic [SLOT_BITS-1:0] slot_counter;
  logic [IDX_W-1:0]     digit_index;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_counter <= '0;
      digit_index  <= '0;
    end else begin
      slot_counter <= slot_counter + 1'b1;
      if (&slot_counter) digit_index <= (digit_index == LAST_IDX) ? '0 : digit_index + 1'b1;
    end
  end

  // Brightness compares against the top slot bits; short counters are zero-padded.
  logic [BRIGHT_BITS-1:0] slot_level;
  generate
    if (SLOT_BITS >= BRIGHT_BITS) begin : g_level_slice
      assign slot_level = slot_counter[SLOT_BITS-1 -: BRIGHT_BITS];
    end else begin : g_level_pad
      assign slot_level = {slot_counter, {(BRIGHT_BITS - SLOT_BITS){1'b0}}};
    end
  endgenerate

  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_lead_zero;
  logic                  all_zero;
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] anode_next;

  always_comb begin
    cur_nib       = 4'd0;
    cur_dp        = 1'b0;
    cur_lead_zero = 1'b0;
    all_zero      = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero & (digits[4*i +: 4] == 4'd0);
      if (IDX_W'(i) == digit_index) begin
        cur_nib       = digits[4*i +: 4];
        cur_dp        = dp_mask[i];
        cur_lead_zero = all_zero;
      end
    end

    if (overflow)
      seg_next = SEG_DASH;
    else if (blank_leading && digit_index != '0 && cur_lead_zero)
      seg_next = SEG_BLANK;
    else
      seg_next = seg_decode(cur_nib);

    if (slot_level <= brightness)
      anode_next = ~(NUM_DIGITS'(1) << digit_index);
    else
      anode_next = {NUM_DIGITS{ANODE_OFF}};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      anode_signals <= {NUM_DIGITS{ANODE_OFF}};
      display_out   <= SEG_BLANK;
      dp_out        <= 1'b1;
    end else begin
      anode_signals <= anode_next;
      display_out   <= seg_next;
      dp_out        <= ~cur_dp;
    end
  end

endmodule
